// File: rtl/sram_cell_arbiter_2to1_pkg.sv
// Shared encodings for the 2:1 SRAM cell arbiter.
package sram_cell_arbiter_2to1_pkg;

  // Who owns an outstanding read / a grant.
  typedef enum logic [1:0] {
    RQ_NONE = 2'd0,
    RQ0     = 2'd1,
    RQ1     = 2'd2
  } rq_id_e;

  // Burst-lock FSM.
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } lock_state_e;

  // Byte-lane count for a data width.
  function automatic int num_byte(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/sram_cell_arbiter_2to1_rr_arbiter_2.sv
// Two-input grant logic: round-robin or fixed priority, with burst-lock override.
module rr_arbiter_2
  import sram_cell_arbiter_2to1_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic       clk,
  input  logic       rstnn,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  lock_state_e state, state_nxt;
  logic        last_grant;  // 1 = requester 1 won last, so requester 0 wins the next tie

  // Same-cycle grant; a lock owner blocks the other side even while idle.
  always_comb begin
    gnt = 2'b00;
    case (state)
      LOCKED0: gnt[0] = req[0];
      LOCKED1: gnt[1] = req[1];
      default: begin
        if (req[0] && req[1]) begin
          if ((FIXED_PRIORITY != 0) || last_grant) gnt[0] = 1'b1;
          else                                     gnt[1] = 1'b1;
        end else begin
          gnt = req;
        end
      end
    endcase
  end

  // Lock transitions; requester 0 never locks under fixed priority since it already wins.
  always_comb begin
    state_nxt = state;
    case (state)
      UNLOCKED: begin
        if (gnt[0] && lock[0] && (FIXED_PRIORITY == 0)) state_nxt = LOCKED0;
        else if (gnt[1] && lock[1])                     state_nxt = LOCKED1;
      end
      LOCKED0: if (!lock[0] && (gnt[0] || !req[0])) state_nxt = UNLOCKED;
      LOCKED1: if (!lock[1] && (gnt[1] || !req[1])) state_nxt = UNLOCKED;
      default: state_nxt = UNLOCKED;
    endcase
  end

  // Lock state and round-robin pointer.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state      <= UNLOCKED;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (|gnt) last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/sram_cell_arbiter_2to1.sv
// Shares one synchronous-read SRAM cell between two requesters and steers
// each read result back to the requester that issued it.
module sram_cell_arbiter_2to1
  import sram_cell_arbiter_2to1_pkg::*;
#(
  parameter int BW_INDEX       = 11,
  parameter int WIDTH          = 128,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  rstnn,
  input  logic [BW_INDEX-1:0]   rq0_index,
  input  logic                  rq0_enable,
  input  logic                  rq0_wenable,
  input  logic [WIDTH/8-1:0]    rq0_wbyte,
  input  logic [WIDTH-1:0]      rq0_wdata,
  input  logic                  rq0_lock,
  output logic                  rq0_stall,
  output logic                  rq0_rvalid,
  output logic [WIDTH-1:0]      rq0_rdata,
  input  logic [BW_INDEX-1:0]   rq1_index,
  input  logic                  rq1_enable,
  input  logic                  rq1_wenable,
  input  logic [WIDTH/8-1:0]    rq1_wbyte,
  input  logic [WIDTH-1:0]      rq1_wdata,
  input  logic                  rq1_lock,
  output logic                  rq1_stall,
  output logic                  rq1_rvalid,
  output logic [WIDTH-1:0]      rq1_rdata,
  output logic [BW_INDEX-1:0]   cell_index,
  output logic                  cell_enable,
  output logic                  cell_wenable,
  output logic [WIDTH/8-1:0]    cell_wbyte,
  output logic [WIDTH-1:0]      cell_wdata,
  output logic                  cell_renable,
  input  logic [WIDTH-1:0]      cell_rdata
);

  localparam int NB = num_byte(WIDTH);

  logic [1:0]          gnt;
  logic [BW_INDEX-1:0] idx_q;
  logic                we_q;
  logic [NB-1:0]       wbyte_q;
  logic [WIDTH-1:0]    wdata_q;
  rq_id_e              rd_owner;
  logic [WIDTH-1:0]    hold0, hold1;

  rr_arbiter_2 #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_arb (
    .clk   (clk),
    .rstnn (rstnn),
    .req   ({rq1_enable, rq0_enable}),
    .lock  ({rq1_lock, rq0_lock}),
    .gnt   (gnt)
  );

  assign rq0_stall = rq0_enable & ~gnt[0];
  assign rq1_stall = rq1_enable & ~gnt[1];

  // Winner drives the cell; with no grant the last address/data stay on the bus.
  always_comb begin
    cell_index   = idx_q;
    cell_wenable = we_q;
    cell_wbyte   = wbyte_q;
    cell_wdata   = wdata_q;
    cell_enable  = 1'b0;
    cell_renable = 1'b0;
    if (gnt[1]) begin
      cell_index   = rq1_index;
      cell_wenable = rq1_wenable;
      cell_wbyte   = rq1_wbyte;
      cell_wdata   = rq1_wdata;
      cell_enable  = 1'b1;
      cell_renable = ~rq1_wenable;
    end else if (gnt[0]) begin
      cell_index   = rq0_index;
      cell_wenable = rq0_wenable;
      cell_wbyte   = rq0_wbyte;
      cell_wdata   = rq0_wdata;
      cell_enable  = 1'b1;
      cell_renable = ~rq0_wenable;
    end
  end

  // Remember the last granted access so idle cycles keep the bus stable.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      idx_q   <= '0;
      we_q    <= 1'b0;
      wbyte_q <= '0;
      wdata_q <= '0;
    end else if (|gnt) begin
      idx_q   <= cell_index;
      we_q    <= cell_wenable;
      wbyte_q <= cell_wbyte;
      wdata_q <= cell_wdata;
    end
  end

  // Tag each granted read with its issuer; the cell answers one cycle later.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn)                     rd_owner <= RQ_NONE;
    else if (gnt[0] && !rq0_wenable) rd_owner <= RQ0;
    else if (gnt[1] && !rq1_wenable) rd_owner <= RQ1;
    else                             rd_owner <= RQ_NONE;
  end

  assign rq0_rvalid = (rd_owner == RQ0);
  assign rq1_rvalid = (rd_owner == RQ1);
  assign rq0_rdata  = rq0_rvalid ? cell_rdata : hold0;
  assign rq1_rdata  = rq1_rvalid ? cell_rdata : hold1;

  // Per-requester copy of the last returned word.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (rq0_rvalid) hold0 <= cell_rdata;
      if (rq1_rvalid) hold1 <= cell_rdata;
    end
  end

endmodule

// File: tb/tb_sram_cell_arbiter_2to1.sv
// Directed bench: a round-robin instance and a fixed-priority instance share
// the same requester stimulus, each with its own cell model.
module tb_sram_cell_arbiter_2to1;

  logic         clk = 1'b0;
  logic         rstnn;
  logic [10:0]  rq0_index, rq1_index;
  logic         rq0_enable, rq0_wenable, rq0_lock;
  logic         rq1_enable, rq1_wenable, rq1_lock;
  logic [15:0]  rq0_wbyte, rq1_wbyte;
  logic [127:0] rq0_wdata, rq1_wdata;

  logic         r_rq0_stall, r_rq0_rvalid, r_rq1_stall, r_rq1_rvalid;
  logic [127:0] r_rq0_rdata, r_rq1_rdata;
  logic [10:0]  r_cell_index;
  logic         r_cell_enable, r_cell_wenable, r_cell_renable;
  logic [15:0]  r_cell_wbyte;
  logic [127:0] r_cell_wdata, r_cell_rdata;

  logic         f_rq0_stall, f_rq0_rvalid, f_rq1_stall, f_rq1_rvalid;
  logic [127:0] f_rq0_rdata, f_rq1_rdata;
  logic [10:0]  f_cell_index;
  logic         f_cell_enable, f_cell_wenable, f_cell_renable;
  logic [15:0]  f_cell_wbyte;
  logic [127:0] f_cell_wdata, f_cell_rdata;

  logic [127:0] r_mem [0:2047];
  logic [127:0] f_mem [0:2047];

  int ntotal = 0;
  int npass  = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  sram_cell_arbiter_2to1 #(.BW_INDEX(11), .WIDTH(128), .FIXED_PRIORITY(0)) u_rr (
    .clk(clk), .rstnn(rstnn),
    .rq0_index(rq0_index), .rq0_enable(rq0_enable), .rq0_wenable(rq0_wenable),
    .rq0_wbyte(rq0_wbyte), .rq0_wdata(rq0_wdata), .rq0_lock(rq0_lock),
    .rq0_stall(r_rq0_stall), .rq0_rvalid(r_rq0_rvalid), .rq0_rdata(r_rq0_rdata),
    .rq1_index(rq1_index), .rq1_enable(rq1_enable), .rq1_wenable(rq1_wenable),
    .rq1_wbyte(rq1_wbyte), .rq1_wdata(rq1_wdata), .rq1_lock(rq1_lock),
    .rq1_stall(r_rq1_stall), .rq1_rvalid(r_rq1_rvalid), .rq1_rdata(r_rq1_rdata),
    .cell_index(r_cell_index), .cell_enable(r_cell_enable), .cell_wenable(r_cell_wenable),
    .cell_wbyte(r_cell_wbyte), .cell_wdata(r_cell_wdata), .cell_renable(r_cell_renable),
    .cell_rdata(r_cell_rdata)
  );

  sram_cell_arbiter_2to1 #(.BW_INDEX(11), .WIDTH(128), .FIXED_PRIORITY(1)) u_fp (
    .clk(clk), .rstnn(rstnn),
    .rq0_index(rq0_index), .rq0_enable(rq0_enable), .rq0_wenable(rq0_wenable),
    .rq0_wbyte(rq0_wbyte), .rq0_wdata(rq0_wdata), .rq0_lock(rq0_lock),
    .rq0_stall(f_rq0_stall), .rq0_rvalid(f_rq0_rvalid), .rq0_rdata(f_rq0_rdata),
    .rq1_index(rq1_index), .rq1_enable(rq1_enable), .rq1_wenable(rq1_wenable),
    .rq1_wbyte(rq1_wbyte), .rq1_wdata(rq1_wdata), .rq1_lock(rq1_lock),
    .rq1_stall(f_rq1_stall), .rq1_rvalid(f_rq1_rvalid), .rq1_rdata(f_rq1_rdata),
    .cell_index(f_cell_index), .cell_enable(f_cell_enable), .cell_wenable(f_cell_wenable),
    .cell_wbyte(f_cell_wbyte), .cell_wdata(f_cell_wdata), .cell_renable(f_cell_renable),
    .cell_rdata(f_cell_rdata)
  );

  // Cell models: synchronous read, byte-masked write.
  always @(posedge clk) begin
    if (r_cell_enable) begin
      if (r_cell_wenable) begin
        for (int b = 0; b < 16; b++)
          if (r_cell_wbyte[b]) r_mem[r_cell_index][b*8 +: 8] <= r_cell_wdata[b*8 +: 8];
      end else begin
        r_cell_rdata <= r_mem[r_cell_index];
      end
    end
  end

  always @(posedge clk) begin
    if (f_cell_enable) begin
      if (f_cell_wenable) begin
        for (int b = 0; b < 16; b++)
          if (f_cell_wbyte[b]) f_mem[f_cell_index][b*8 +: 8] <= f_cell_wdata[b*8 +: 8];
      end else begin
        f_cell_rdata <= f_mem[f_cell_index];
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  localparam logic [127:0] DA5 = {16{8'hA5}};
  localparam logic [127:0] D3C = {16{8'h3C}};
  localparam logic [127:0] D11 = {16{8'h11}};
  localparam logic [127:0] D22 = {16{8'h22}};
  localparam logic [127:0] D33 = {16{8'h33}};
  localparam logic [127:0] DBE = {{15{8'hFF}}, 8'h00};

  initial begin
    rstnn = 1'b0;
    rq0_index = '0; rq0_enable = 0; rq0_wenable = 0; rq0_wbyte = '0; rq0_wdata = '0; rq0_lock = 0;
    rq1_index = '0; rq1_enable = 0; rq1_wenable = 0; rq1_wbyte = '0; rq1_wdata = '0; rq1_lock = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    settle();
    chk("rst_stall0",  r_rq0_stall,  1'b0);
    chk("rst_rvalid0", r_rq0_rvalid, 1'b0);
    chk("rst_rdata0",  r_rq0_rdata,  '0);
    chk("rst_rvalid1", r_rq1_rvalid, 1'b0);
    chk("rst_rdata1",  r_rq1_rdata,  '0);
    chk("rst_cell_en", r_cell_enable, 1'b0);
    chk("rst_cell_ix", r_cell_index, '0);
    chk("rst_cell_wd", r_cell_wdata, '0);
    step();
    rstnn = 1'b1;

    // Single write then read at index 5
    rq0_enable = 1; rq0_wenable = 1; rq0_index = 11'd5; rq0_wbyte = '1; rq0_wdata = DA5;
    settle();
    chk("wr5_stall0", r_rq0_stall, 1'b0);
    chk("wr5_cell_en", r_cell_enable, 1'b1);
    chk("wr5_cell_we", r_cell_wenable, 1'b1);
    chk("wr5_cell_ix", r_cell_index, 11'd5);
    chk("wr5_cell_re", r_cell_renable, 1'b0);
    step();
    rq0_wenable = 0;
    settle();
    chk("rd5_cell_re", r_cell_renable, 1'b1);
    chk("rd5_stall0", r_rq0_stall, 1'b0);
    chk("rd5_rvalid0_early", r_rq0_rvalid, 1'b0);
    step();
    rq0_enable = 0;
    settle();
    chk("rd5_rvalid0", r_rq0_rvalid, 1'b1);
    chk("rd5_rdata0", r_rq0_rdata, DA5);
    chk("rd5_rvalid1", r_rq1_rvalid, 1'b0);
    chk("idle_cell_en", r_cell_enable, 1'b0);
    chk("idle_cell_ix_held", r_cell_index, 11'd5);
    step();
    settle();
    chk("rd5_rvalid0_once", r_rq0_rvalid, 1'b0);
    chk("rd5_rdata0_held", r_rq0_rdata, DA5);
    step();

    // rq1 writes index 6
    rq1_enable = 1; rq1_wenable = 1; rq1_index = 11'd6; rq1_wbyte = '1; rq1_wdata = D3C;
    settle();
    chk("wr6_stall1", r_rq1_stall, 1'b0);
    chk("wr6_cell_ix", r_cell_index, 11'd6);
    step();

    // Both read every cycle: rq0 (idx5), rq1 (idx6) alternate 0,1,0,1
    rq1_wenable = 0; rq0_enable = 1;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("alt_stall0_c%0d", c), r_rq0_stall, (c % 2 == 1));
      chk($sformatf("alt_stall1_c%0d", c), r_rq1_stall, (c % 2 == 0));
      chk($sformatf("alt_rvalid0_c%0d", c), r_rq0_rvalid, (c == 1 || c == 3));
      chk($sformatf("alt_rvalid1_c%0d", c), r_rq1_rvalid, (c == 2));
      if (c == 1) chk("alt_rdata0", r_rq0_rdata, DA5);
      if (c == 2) chk("alt_rdata1", r_rq1_rdata, D3C);
      step();
    end
    rq0_enable = 0; rq1_enable = 0;
    settle();
    chk("alt_tail_rvalid1", r_rq1_rvalid, 1'b1);
    chk("alt_tail_rdata1", r_rq1_rdata, D3C);
    chk("alt_tail_rvalid0", r_rq0_rvalid, 1'b0);
    step();

    // Fixed priority: both read 3 cycles, rq0 raises lock on the 3rd (ignored there)
    rq0_enable = 1; rq1_enable = 1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) rq0_lock = 1;
      settle();
      chk($sformatf("fp_stall1_c%0d", k), f_rq1_stall, 1'b1);
      chk($sformatf("fp_stall0_c%0d", k), f_rq0_stall, 1'b0);
      if (k > 0) chk($sformatf("fp_rvalid0_c%0d", k), f_rq0_rvalid, 1'b1);
      step();
    end
    rq0_enable = 0; rq0_lock = 0;
    settle();
    chk("fp_c4_stall1", f_rq1_stall, 1'b0);
    chk("fp_c4_cell_ix", f_cell_index, 11'd6);
    chk("fp_c4_cell_re", f_cell_renable, 1'b1);
    chk("fp_c4_rvalid0", f_rq0_rvalid, 1'b1);
    chk("rr_lock0_idle_stall1", r_rq1_stall, 1'b1);
    step();
    rq1_enable = 0;
    settle();
    chk("fp_rvalid1", f_rq1_rvalid, 1'b1);
    chk("fp_rdata1", f_rq1_rdata, D3C);
    step();

    // Burst lock: rq1 writes 10,11,(idle),12 under lock while rq0 keeps reading idx5
    rq0_enable = 1; rq0_wenable = 0; rq0_index = 11'd5;
    rq1_enable = 1; rq1_wenable = 1; rq1_wbyte = '1; rq1_lock = 1;
    rq1_index = 11'd10; rq1_wdata = D11;
    settle();
    chk("lk1_stall0", r_rq0_stall, 1'b1);
    chk("lk1_stall1", r_rq1_stall, 1'b0);
    chk("lk1_cell_ix", r_cell_index, 11'd10);
    chk("lk1_cell_we", r_cell_wenable, 1'b1);
    step();
    rq1_index = 11'd11; rq1_wdata = D22;
    settle();
    chk("lk2_stall0", r_rq0_stall, 1'b1);
    chk("lk2_cell_ix", r_cell_index, 11'd11);
    step();
    rq1_enable = 0;
    settle();
    chk("lk_idle_stall0", r_rq0_stall, 1'b1);
    chk("lk_idle_cell_en", r_cell_enable, 1'b0);
    step();
    rq1_enable = 1; rq1_index = 11'd12; rq1_wdata = D33; rq1_lock = 0;
    settle();
    chk("lk3_stall0", r_rq0_stall, 1'b1);
    chk("lk3_cell_ix", r_cell_index, 11'd12);
    step();
    rq1_enable = 0;
    settle();
    chk("lk_rel_stall0", r_rq0_stall, 1'b0);
    chk("lk_rel_cell_ix", r_cell_index, 11'd5);
    chk("lk_rel_cell_re", r_cell_renable, 1'b1);
    step();
    rq0_enable = 0; rq1_enable = 1; rq1_wenable = 0; rq1_index = 11'd10;
    settle();
    chk("lk_rb_rvalid0", r_rq0_rvalid, 1'b1);
    chk("lk_rb_rdata0", r_rq0_rdata, DA5);
    step();
    rq1_index = 11'd11;
    settle();
    chk("lk_rb10", r_rq1_rdata, D11);
    step();
    rq1_index = 11'd12;
    settle();
    chk("lk_rb11", r_rq1_rdata, D22);
    step();
    rq1_enable = 0;
    settle();
    chk("lk_rb12_rvalid1", r_rq1_rvalid, 1'b1);
    chk("lk_rb12", r_rq1_rdata, D33);
    step();

    // Byte enables: all-ones, then clear byte 0 only
    rq0_enable = 1; rq0_wenable = 1; rq0_index = 11'd20; rq0_wbyte = '1; rq0_wdata = '1;
    settle();
    step();
    rq0_wdata = '0; rq0_wbyte = 16'h0001;
    settle();
    chk("be_cell_wbyte", r_cell_wbyte, 16'h0001);
    step();
    rq0_wenable = 0;
    settle();
    step();
    rq0_enable = 0;
    settle();
    chk("be_rvalid0", r_rq0_rvalid, 1'b1);
    chk("be_rdata0", r_rq0_rdata, DBE);
    step();

    // Reset the cycle after a locked rq0 read is granted
    rq0_enable = 1; rq0_lock = 1;
    settle();
    chk("rr_rd_stall0", r_rq0_stall, 1'b0);
    chk("rr_rd_cell_re", r_cell_renable, 1'b1);
    step();
    rq0_enable = 0; rstnn = 0;
    settle();
    chk("rr_rvalid0", r_rq0_rvalid, 1'b0);
    chk("rr_rdata0", r_rq0_rdata, '0);
    chk("rr_cell_ix", r_cell_index, '0);
    chk("rr_cell_en", r_cell_enable, 1'b0);
    step();
    rstnn = 1;
    rq1_enable = 1; rq1_wenable = 1; rq1_index = 11'd31; rq1_wdata = '1; rq1_wbyte = '1; rq1_lock = 0;
    settle();
    chk("rr_lock_cleared_stall1", r_rq1_stall, 1'b0);
    chk("rr_lock_cleared_cell_en", r_cell_enable, 1'b1);
    step();
    rq0_lock = 0; rq0_enable = 1; rq1_wenable = 0;
    settle();
    chk("rr_tie_stall0", r_rq0_stall, 1'b0);
    chk("rr_tie_stall1", r_rq1_stall, 1'b1);
    chk("rr_tie_cell_ix", r_cell_index, 11'd20);
    step();
    rq0_enable = 0; rq1_enable = 0;
    settle();
    chk("rr_tie_rvalid0", r_rq0_rvalid, 1'b1);
    chk("rr_tie_rdata0", r_rq0_rdata, DBE);
    step();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
